instruction_encoder: RTL and testbench
======================================

# instruction_encoder

- Pipelined RISC-V RV32I instruction encoder, the inverse of the immediate decode path.
- Accepts decoded fields (format, opcode, registers, funct3/funct7, signed 32-bit immediate) over a valid/ready stream and emits the packed 32-bit instruction word.
- When range checking is compiled in, flags immediates that do not fit the format.
- Feeds the self-check and instruction-stimulus generators, so benches round-trip encode→decode.

## Interface
Parameters:
- CNT_W, 16, width of the encoded-instruction counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  input fields valid
- in_ready_o  out  1  encoder can accept fields this cycle
- fmt_i  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6–7 illegal
- opcode_i  in  7  opcode
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7 (R only)
- imm_i  in  32  signed byte-offset/immediate
- out_valid_o  out  1  instr_o valid
- out_ready_i  in  1  downstream accepts
- instr_o  out  32  encoded instruction
- err_o  out  1  immediate range/alignment or illegal-format error, qualified by out_valid_o
- enc_cnt_o  out  CNT_W  count of completed output handshakes

## Operation
Two register stages, S1 and S2.

S1 captures fields on an input handshake (in_valid_i && in_ready_o) and computes the error flag.

S2 packs the fields into instr_o:
- R: funct7|rs2|rs1|f3|rd|op
- I: imm[11:0]|rs1|f3|rd|op
- S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
- B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
- U: imm[31:12]|rd|op
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op

Unused fields are ignored; the encoding does not depend on them.

Errors (only when the checker is compiled in):
- I/S: imm outside [-2048, 2047].
- B: imm outside [-4096, 4094], or imm[0]=1.
- U: imm[11:0]≠0.
- J: imm outside [-2^20, 2^20-2], or imm[0]=1.
- fmt 6/7: instr_o=0, err_o=1.

On an error, the word is still emitted with the imm bits truncated exactly as the packing rules above give them.

enc_cnt_o increments on each out_valid_o && out_ready_i and wraps at 2^CNT_W. Errored words are counted.

## Timing
- Reset values: out_valid_o=0, instr_o=0, err_o=0, enc_cnt_o=0, both stage valids=0. in_ready_o=1 one cycle after reset deasserts.
- Latency: input handshake in cycle N gives out_valid_o in cycle N+2 if there is no backpressure.
- Throughput: one instruction per cycle.
- Stage advance rule:
  - S2 loads when it is empty or its word is consumed this cycle.
  - S1 loads when it is empty or it advances into S2.
  - in_ready_o = !s1_valid || s1_advance. This is combinational from out_ready_i; no skid buffer.
- Holding under backpressure: while out_valid_o && !out_ready_i, instr_o, err_o and out_valid_o hold stable. At most 2 instructions are buffered.
- Simultaneous accept and emit in one cycle is legal and loses no data.
- Reset mid-operation: both stages flush immediately and asynchronously; in-flight words are dropped and enc_cnt_o clears.
- Input fields are only sampled on a handshake. Changing them while in_ready_o=0 has no effect.

## Configuration
IMM_ENC_CHECK_EN:
- Defined: the range/alignment/illegal-format checker is present and err_o behaves as specified.
- Undefined: the checker is absent, err_o is tied 0, out-of-range immediates are silently truncated, and fmt 6/7 still produces instr_o=0.

## Structure
- riscv_pkg holds:
  - the format enum (FMT_R..FMT_J)
  - opcode constants (OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_IMM, OP_REG)
  - imm range limit localparams
- Sub-module instr_pack: purely combinational field-to-word packer, instantiated in S2. The same packer is reusable by the stimulus generator.
- Pipeline control and the checker live in instruction_encoder.

## Test plan
- I, rd=1, rs1=0, f3=0, op=0x13, imm=1 → 0x00100093, err=0. Same with imm=-1 → 0xFFF00093.
- S, rs1=1, rs2=0, f3=0, op=0x23, imm=1 → 0x000080A3. B, rs1=1, rs2=2, op=0x63, imm=12 → 0x00208663.
- U, rd=1, op=0x37, imm=0x12345000 → 0x123450B7. J, rd=0, op=0x6F, imm=8 → 0x0080006F.
- Checker compiled in:
  - B imm=13 → err_o=1.
  - I imm=2048 → err_o=1, with instr_o imm field = 0x800.
  - fmt=7 → instr_o=0, err_o=1.
- Backpressure:
  - Stream 5 words with out_ready_i low for 4 cycles → in_ready_o drops after 2 accepts.
  - Outputs stay stable while stalled.
  - All 5 words emerge in order; enc_cnt_o=5.
- Assert rst_i asynchronously with 2 words in flight → out_valid_o=0 and enc_cnt_o=0 immediately. Next accepted word is emitted 2 cycles after its handshake.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I encoder shared types: instruction formats, opcodes, imm limits.
// Imported by the packer and the encoder top.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field-to-word packer.
// Illegal formats pack to an all-zero word.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word
);

  // Scatter immediate bits into the slots each format defines
  always_comb begin
    o_word = '0;
    case (i_fmt)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1,
                       i_funct3, i_rd, i_opcode};
      FMT_I: o_word = {i_imm[11:0], i_rs1,
                       i_funct3, i_rd, i_opcode};
      FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs1,
                       i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_word = {i_imm[12], i_imm[10:5],
                       i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_word = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_word = {i_imm[20], i_imm[10:1],
                       i_imm[11], i_imm[19:12],
                       i_rd, i_opcode};
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready on both sides.
// Define IMM_ENC_CHECK_EN to build in the immediate range checker.
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       fmt_i,
  input  logic [6:0]       opcode_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [31:0]      imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      instr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] enc_cnt_o
);

  logic             r_s1_valid;
  logic [2:0]       r_s1_fmt;
  logic [6:0]       r_s1_op;
  logic [4:0]       r_s1_rd;
  logic [4:0]       r_s1_rs1;
  logic [4:0]       r_s1_rs2;
  logic [2:0]       r_s1_f3;
  logic [6:0]       r_s1_f7;
  logic [31:0]      r_s1_imm;
  logic             r_s1_err;
  logic             r_s2_valid;
  logic [31:0]      r_s2_instr;
  logic             r_s2_err;
  logic [CNT_W-1:0] r_cnt;

  logic        w_s2_load;
  logic        w_s1_adv;
  logic        w_s1_load;
  logic        w_in_hs;
  logic        w_in_err;
  logic [31:0] w_word;

  assign w_s2_load = !r_s2_valid || out_ready_i;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign w_s1_load = !r_s1_valid || w_s1_adv;
  assign w_in_hs   = in_valid_i && w_s1_load;

  assign in_ready_o  = w_s1_load;
  assign out_valid_o = r_s2_valid;
  assign instr_o     = r_s2_instr;
  assign err_o       = r_s2_err;
  assign enc_cnt_o   = r_cnt;

`ifdef IMM_ENC_CHECK_EN
  logic signed [31:0] w_imm_s;
  assign w_imm_s = $signed(imm_i);

  // Flag immediates that cannot be represented in the chosen format
  always_comb begin
    w_in_err = 1'b0;
    case (fmt_i)
      FMT_R: w_in_err = 1'b0;
      FMT_I, FMT_S:
        w_in_err = (w_imm_s < IMM12_MIN) ||
                   (w_imm_s > IMM12_MAX);
      FMT_B:
        w_in_err = (w_imm_s < IMMB_MIN) ||
                   (w_imm_s > IMMB_MAX) ||
                   imm_i[0];
      FMT_U: w_in_err = |imm_i[11:0];
      FMT_J:
        w_in_err = (w_imm_s < IMMJ_MIN) ||
                   (w_imm_s > IMMJ_MAX) ||
                   imm_i[0];
      default: w_in_err = 1'b1;
    endcase
  end
`else
  assign w_in_err = 1'b0;
`endif

  instr_pack u_pack (
    .i_fmt    (r_s1_fmt),
    .i_opcode (r_s1_op),
    .i_rd     (r_s1_rd),
    .i_rs1    (r_s1_rs1),
    .i_rs2    (r_s1_rs2),
    .i_funct3 (r_s1_f3),
    .i_funct7 (r_s1_f7),
    .i_imm    (r_s1_imm),
    .o_word   (w_word)
  );

  // S1: capture decoded fields and their error flag on handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_fmt   <= '0;
      r_s1_op    <= '0;
      r_s1_rd    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_f3    <= '0;
      r_s1_f7    <= '0;
      r_s1_imm   <= '0;
      r_s1_err   <= 1'b0;
    end else begin
      if (w_s1_load) r_s1_valid <= in_valid_i;
      if (w_in_hs) begin
        r_s1_fmt <= fmt_i;
        r_s1_op  <= opcode_i;
        r_s1_rd  <= rd_i;
        r_s1_rs1 <= rs1_i;
        r_s1_rs2 <= rs2_i;
        r_s1_f3  <= funct3_i;
        r_s1_f7  <= funct7_i;
        r_s1_imm <= imm_i;
        r_s1_err <= w_in_err;
      end
    end
  end

  // S2: hold the packed word until downstream takes it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_word;
        r_s2_err   <= r_s1_err;
      end
    end
  end

  // Count every completed output handshake, errored or not
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_s2_valid && out_ready_i) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized and directed bench for instruction_encoder.
// Reference model derives words and errors from the format rules.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  op = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic        err;
  logic [15:0] enc_cnt;

  int total = 0;
  int bad = 0;

`ifdef IMM_ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  instruction_encoder #(.CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .fmt_i       (fmt),
    .opcode_i    (op),
    .rd_i        (rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .funct3_i    (f3),
    .funct7_i    (f7),
    .imm_i       (imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .instr_o     (instr),
    .err_o       (err),
    .enc_cnt_o   (enc_cnt)
  );

  function automatic longint fld(longint u, int hi, int lo);
    return (u / (64'd1 << lo)) % (64'd1 << (hi - lo + 1));
  endfunction

  function automatic logic [31:0] ref_word(
    int f, int o, int d, int s1, int s2,
    int t3, int t7, logic [31:0] im);
    longint u = longint'(im);
    longint base = longint'(o) + d * 128;
    longint r;
    longint regs = s1 * 32768 + t3 * 4096;
    case (f)
      0: r = t7 * (1 << 25) + s2 * (1 << 20)
             + regs + base;
      1: r = fld(u, 11, 0) * (1 << 20) + regs + base;
      2: r = fld(u, 11, 5) * (1 << 25) + s2 * (1 << 20)
             + regs + fld(u, 4, 0) * 128 + o;
      3: r = fld(u, 12, 12) * (64'd1 << 31)
             + fld(u, 10, 5) * (1 << 25)
             + s2 * (1 << 20) + regs
             + fld(u, 4, 1) * 256
             + fld(u, 11, 11) * 128 + o;
      4: r = fld(u, 31, 12) * 4096 + base;
      5: r = fld(u, 20, 20) * (64'd1 << 31)
             + fld(u, 10, 1) * (1 << 21)
             + fld(u, 11, 11) * (1 << 20)
             + fld(u, 19, 12) * 4096 + base;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic ref_err(int f, logic [31:0] im);
    int s = int'(im);
    bit e;
    case (f)
      0: e = 0;
      1, 2: e = (s < -2048) || (s > 2047);
      3: e = (s < -4096) || (s > 4094) || (s % 2 != 0);
      4: e = (im % 4096) != 0;
      5: e = (s < -1048576) || (s > 1048574)
             || (s % 2 != 0);
      default: e = 1;
    endcase
    return CHK ? e : 1'b0;
  endfunction

  function automatic logic [31:0] rand_imm();
    int bnd[15] = '{-2048, 2047, 2048, -2049, -4096,
                    4094, 4096, -4098, 4095, -1048576,
                    1048574, 1048576, -1048578,
                    32'h12345000, 32'h12345001};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return 32'(bnd[$urandom_range(0, 14)]);
      default:
        return 32'($urandom_range(0, 4194303))
               - 32'd2097152;
    endcase
  endfunction

  task automatic rand_fields();
    fmt = 3'($urandom_range(0, 7));
    op  = 7'($urandom);
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    f3  = 3'($urandom);
    f7  = 7'($urandom);
    imm = rand_imm();
  endtask

  function automatic exp_t model_cur();
    exp_t x;
    x.w = ref_word(int'(fmt), int'(op), int'(rd),
                   int'(rs1), int'(rs2), int'(f3),
                   int'(f7), imm);
    x.e = ref_err(int'(fmt), imm);
    return x;
  endfunction

  task automatic do_reset();
    #1 rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Sends one word into an empty pipe; returns output and latency.
  task automatic encode_one(
    input logic [2:0] f, input logic [6:0] o,
    input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic [2:0] t3,
    input logic [6:0] t7, input logic [31:0] im,
    output logic [31:0] w, output logic e,
    output int lat);
    fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2;
    f3 = t3; f7 = t7; imm = im;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    imm = $urandom;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      #1 lat++;
    end
    w = instr;
    e = err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++;
    if (out_valid !== 1'b0 || instr !== 32'd0 ||
        err !== 1'b0 || enc_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b i=%h e=%b c=%0d want 0",
               out_valid, instr, err, enc_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] w;
    logic e;
    int lat;
    logic [31:0] exp_w[6] = '{32'h00100093, 32'hFFF00093,
                              32'h000080A3, 32'h00208663,
                              32'h123450B7, 32'h0080006F};
    logic [2:0] vf[6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [6:0] vo[6] = '{7'h13, 7'h13, 7'h23, 7'h63,
                          7'h37, 7'h6F};
    logic [4:0] vd[6] = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd1, 5'd0};
    logic [4:0] v1[6] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0};
    logic [4:0] v2[6] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0};
    logic [31:0] vi[6] = '{32'd1, 32'hFFFFFFFF, 32'd1,
                           32'd12, 32'h12345000, 32'd8};
    for (int k = 0; k < 6; k++) begin
      encode_one(vf[k], vo[k], vd[k], v1[k], v2[k],
                 3'd0, 7'd0, vi[k], w, e, lat);
      total++;
      if (w !== exp_w[k] || e !== 1'b0 || lat != 2) begin
        bad++;
        $display("FAIL vec%0d got %h e=%b lat=%0d want %h e=0 lat=2",
                 k, w, e, lat, exp_w[k]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] w;
    logic e;
    int lat;
    encode_one(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0,
               7'd0, 32'd13, w, e, lat);
    total++;
    if (e !== CHK ||
        w !== ref_word(3, 7'h63, 0, 1, 2, 0, 0, 32'd13)) begin
      bad++;
      $display("FAIL err_b13 got %h e=%b want e=%b", w, e, CHK);
    end
    encode_one(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0,
               7'd0, 32'd2048, w, e, lat);
    total++;
    if (e !== CHK || w[31:20] !== 12'h800) begin
      bad++;
      $display("FAIL err_i2048 got %h e=%b want imm 800 e=%b",
               w, e, CHK);
    end
    encode_one(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1,
               7'd1, 32'd4, w, e, lat);
    total++;
    if (w !== 32'd0 || e !== CHK) begin
      bad++;
      $display("FAIL err_fmt7 got %h e=%b want 0 e=%b",
               w, e, CHK);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    int cyc = 0;
    bit hold = 0;
    logic [31:0] hw;
    logic he;
    exp_t x;
    exp_t vals[5];
    logic [2:0] fs[5];
    logic [31:0] is[5];
    do_reset();
    for (int k = 0; k < 5; k++) begin
      fs[k] = 3'($urandom_range(0, 5));
      is[k] = rand_imm();
    end
    out_ready = 1'b0;
    while ((idx < 5 || sb.size() != 0) && cyc < 40) begin
      if (cyc == 4) out_ready = 1'b1;
      in_valid = (idx < 5);
      if (idx < 5) begin
        fmt = fs[idx]; imm = is[idx];
        op = 7'(idx + 1); rd = 5'(idx);
        rs1 = 5'(idx + 7); rs2 = 5'(idx + 9);
        f3 = 3'(idx); f7 = 7'(idx * 3);
      end
      #1;
      if (cyc == 4) begin
        total++;
        if (idx != 2) begin
          bad++;
          $display("FAIL bp_accepts got %0d want 2", idx);
        end
      end
      if (hold) begin
        total++;
        if (out_valid !== 1'b1 || instr !== hw ||
            err !== he) begin
          bad++;
          $display("FAIL bp_stable got v=%b %h want 1 %h",
                   out_valid, instr, hw);
        end
      end
      hold = out_valid && !out_ready;
      hw = instr;
      he = err;
      if (out_valid && out_ready) begin
        x = sb.pop_front();
        got++;
        total++;
        if (instr !== x.w || err !== x.e) begin
          bad++;
          $display("FAIL bp_word%0d got %h e=%b want %h e=%b",
                   got, instr, err, x.w, x.e);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model_cur());
        idx++;
      end
      if (cyc == 3) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_ready got %b want 0", in_ready);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (got != 5 || enc_cnt !== 16'd5) begin
      bad++;
      $display("FAIL bp_count got %0d cnt=%0d want 5",
               got, enc_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    logic e;
    int lat;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_fields();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || enc_cnt !== 16'd0) begin
      bad++;
      $display("FAIL async_rst got v=%b cnt=%0d want 0 0",
               out_valid, enc_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    encode_one(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2,
               7'd0, 32'hFFFFFFF0, w, e, lat);
    total++;
    if (lat != 2 || e !== 1'b0 ||
        w !== ref_word(2, 7'h23, 0, 3, 4, 2, 0,
                       32'hFFFFFFF0)) begin
      bad++;
      $display("FAIL post_rst got %h lat=%0d e=%b", w, lat, e);
    end
  endtask

  task automatic test_random();
    int n = 0;
    bit hold = 0;
    logic [31:0] hw;
    logic he;
    exp_t x;
    int cyc = 0;
    do_reset();
    while (cyc < 400 || (sb.size() != 0 && cyc < 440)) begin
      if (cyc < 400) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_fields();
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (hold) begin
        total++;
        if (out_valid !== 1'b1 || instr !== hw ||
            err !== he) begin
          bad++;
          $display("FAIL rnd_stable got v=%b %h want %h",
                   out_valid, instr, hw);
        end
      end
      hold = out_valid && !out_ready;
      hw = instr;
      he = err;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra got %h want none", instr);
        end else begin
          x = sb.pop_front();
          n++;
          if (instr !== x.w || err !== x.e) begin
            bad++;
            $display("FAIL rnd_word%0d got %h e=%b want %h e=%b",
                     n, instr, err, x.w, x.e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model_cur());
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (sb.size() != 0 || enc_cnt !== 16'(n)) begin
      bad++;
      $display("FAIL rnd_drain got left=%0d cnt=%0d want 0 %0d",
               sb.size(), enc_cnt, n);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_errors();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
